// File: rtl/encrypt_pipe_shift_rot.sv
// Second stage of the encrypt shift pipe: rotates a one-hot letter index by the
// active key (mod 26), re-encodes it as ASCII and cycles the key k1->k2->k3.
module encrypt_pipe_shift_rot #(
    parameter int NUM_LETTERS = 26,
    parameter int ROT_W       = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [7:0]       k1,
    input  logic [7:0]       k2,
    input  logic [7:0]       k3,
    input  logic [ROT_W-1:0] rot_freq,
    input  logic             shift_en,
    input  logic             shift_amt,
    input  logic             mode,
    input  logic             is_alpha_upper_case,
    input  logic             is_alpha_low_case,
    input  logic [31:0]      extended_shift_data,
    output logic [7:0]       dout,
    output logic             en_out,
    output logic [1:0]       key_sel_out,
    output logic             onehot_err_out
);

    localparam int IDX_W = $clog2(NUM_LETTERS);
    localparam int SUM_W = IDX_W + 1;

    // Handshake: en is a valid-only strobe with no ready; every cycle with en=1
    // delivers one char, and en_out mirrors it exactly one cycle later.

    logic [NUM_LETTERS-1:0] w_letters;
    logic                   w_is_alpha;
    logic                   w_onehot;
    logic                   w_err;
    logic                   w_counted;
    logic [IDX_W-1:0]       w_idx;
    logic [7:0]             w_key_raw;
    logic [IDX_W-1:0]       w_key;
    logic [SUM_W-1:0]       w_addend;
    logic [SUM_W-1:0]       w_sum;
    logic [SUM_W-1:0]       w_rot;
    logic [7:0]             w_base;
    logic [7:0]             w_char;
    logic [1:0]             w_key_sel_next;
    logic                   w_unused;

    logic [7:0]             r_dout;
    logic                   r_en_out;
    logic [1:0]             r_key_sel_out;
    logic                   r_onehot_err;
    logic [1:0]             r_key_sel;
    logic [ROT_W-1:0]       r_rot_cnt;

    assign w_letters  = extended_shift_data[NUM_LETTERS-1:0];
    assign w_unused   = ^extended_shift_data[31:NUM_LETTERS];
    assign w_is_alpha = is_alpha_upper_case | is_alpha_low_case;
    assign w_onehot   = $onehot(w_letters);
    assign w_err      = w_is_alpha & ~w_onehot;
    assign w_counted  = en & mode & shift_en & w_is_alpha & w_onehot;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < NUM_LETTERS; i++) begin
            if (w_letters[i]) w_idx = IDX_W'(i);
        end
    end

    always_comb begin
        w_key_raw = k1;
        case (r_key_sel)
            2'd1:    w_key_raw = k2;
            2'd2:    w_key_raw = k3;
            default: w_key_raw = k1;
        endcase
    end

    assign w_key = IDX_W'(w_key_raw % 8'(NUM_LETTERS));

    // Backward shift adds (26 - key) so a single conditional subtract wraps both directions.
    assign w_addend = shift_amt ? (SUM_W'(NUM_LETTERS) - SUM_W'(w_key)) : SUM_W'(w_key);
    assign w_sum    = SUM_W'(w_idx) + w_addend;
    assign w_rot    = (w_sum >= SUM_W'(NUM_LETTERS)) ? (w_sum - SUM_W'(NUM_LETTERS)) : w_sum;
    assign w_base   = is_alpha_upper_case ? 8'd65 : 8'd97;
    assign w_char   = w_base + 8'(w_rot);

    assign w_key_sel_next = (r_key_sel == 2'd2) ? 2'd0 : (r_key_sel + 2'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout        <= '0;
            r_en_out      <= 1'b0;
            r_key_sel_out <= '0;
            r_onehot_err  <= 1'b0;
            r_key_sel     <= '0;
            r_rot_cnt     <= '0;
        end else begin
            r_en_out <= en;
            if (en) begin
                r_dout        <= w_counted ? w_char : extended_shift_data[7:0];
                r_key_sel_out <= r_key_sel;
                r_onehot_err  <= w_err;
            end
            if (!mode) begin
                r_key_sel <= '0;
                r_rot_cnt <= '0;
            end else if (w_counted && (rot_freq != '0)) begin
                // >= so a shrunken rot_freq wraps on the next counted char.
                if (r_rot_cnt >= (rot_freq - ROT_W'(1))) begin
                    r_rot_cnt <= '0;
                    r_key_sel <= w_key_sel_next;
                end else begin
                    r_rot_cnt <= r_rot_cnt + ROT_W'(1);
                end
            end
        end
    end

    assign dout           = r_dout;
    assign en_out         = r_en_out;
    assign key_sel_out    = r_key_sel_out;
    assign onehot_err_out = r_onehot_err;

endmodule

// File: tb/tb_encrypt_pipe_shift_rot.sv
// Bench for encrypt_pipe_shift_rot: directed steps from the test plan followed
// by random chars, all checked against a letter-arithmetic reference model.
module tb_encrypt_pipe_shift_rot;

    localparam int NL = 26;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [7:0]    k1, k2, k3;
    logic [RW-1:0] rot_freq;
    logic          shift_en, shift_amt, mode, up, lo;
    logic [31:0]   data;
    logic [7:0]    dout;
    logic          en_out;
    logic [1:0]    key_sel_out;
    logic          onehot_err_out;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int          m_key_num;
    int          m_in_group;
    logic [7:0]  m_dout;
    logic        m_en;
    logic [1:0]  m_kso;
    logic        m_err;

    logic [7:0] exp_rot_ch [7] = '{8'h42, 8'h42, 8'h43, 8'h43, 8'h44, 8'h44, 8'h42};
    logic [1:0] exp_rot_ks [7] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0};
    logic [7:0] exp_mix    [5] = '{8'h42, 8'h20, 8'h42, 8'h20, 8'h43};

    encrypt_pipe_shift_rot #(.NUM_LETTERS(NL), .ROT_W(RW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .en                  (en),
        .k1                  (k1),
        .k2                  (k2),
        .k3                  (k3),
        .rot_freq            (rot_freq),
        .shift_en            (shift_en),
        .shift_amt           (shift_amt),
        .mode                (mode),
        .is_alpha_upper_case (up),
        .is_alpha_low_case   (lo),
        .extended_shift_data (data),
        .dout                (dout),
        .en_out              (en_out),
        .key_sel_out         (key_sel_out),
        .onehot_err_out      (onehot_err_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] oh(input int i);
        logic [31:0] one;
        one = 32'd1;
        return one << i;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_key_num  = 0;
        m_in_group = 0;
        m_dout     = 8'h00;
        m_en       = 1'b0;
        m_kso      = 2'd0;
        m_err      = 1'b0;
    endtask

    // Caesar rule on letter positions; the key cycles after rot_freq letters.
    task automatic model_step();
        int  idx, key, res, ones;
        bit  counted;
        counted = 0;
        ones = $countones(data[NL-1:0]);
        if (en) begin
            m_kso = 2'(m_key_num);
            if ((up || lo) && ones != 1) begin
                m_dout = data[7:0];
                m_err  = 1'b1;
            end else begin
                m_err = 1'b0;
                if (mode && shift_en && (up || lo)) begin
                    idx = 0;
                    for (int i = 0; i < NL; i++) if (data[i]) idx = i;
                    key = (m_key_num == 0) ? int'(k1) : (m_key_num == 1) ? int'(k2) : int'(k3);
                    key = key % 26;
                    res = shift_amt ? (idx + 26 - key) % 26 : (idx + key) % 26;
                    m_dout = 8'((up ? 65 : 97) + res);
                    counted = 1;
                end else begin
                    m_dout = data[7:0];
                end
            end
        end
        m_en = en;
        if (!mode) begin
            m_key_num  = 0;
            m_in_group = 0;
        end else if (counted && rot_freq != 0) begin
            m_in_group = m_in_group + 1;
            if (m_in_group >= int'(rot_freq)) begin
                m_in_group = 0;
                m_key_num  = (m_key_num + 1) % 3;
            end
        end
    endtask

    task automatic step(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ":en_out"}, 32'(en_out), 32'(m_en));
        chk({tag, ":dout"}, 32'(dout), 32'(m_dout));
        chk({tag, ":key_sel_out"}, 32'(key_sel_out), 32'(m_kso));
        chk({tag, ":onehot_err"}, 32'(onehot_err_out), 32'(m_err));
    endtask

    task automatic set_char(input logic e, input logic u, input logic l, input logic [31:0] d);
        en = e; up = u; lo = l; data = d;
    endtask

    task automatic clear_counters();
        en = 1'b0; mode = 1'b0;
        step("clear");
        mode = 1'b1;
    endtask

    initial begin
        int kind, a, b;
        rst = 1'b0; en = 1'b0; k1 = 8'd0; k2 = 8'd0; k3 = 8'd0; rot_freq = '0;
        shift_en = 1'b0; shift_amt = 1'b0; mode = 1'b0; up = 1'b0; lo = 1'b0; data = '0;
        model_reset();
        #12;
        chk("reset:dout", 32'(dout), 32'h0);
        chk("reset:en_out", 32'(en_out), 32'h0);
        chk("reset:key_sel_out", 32'(key_sel_out), 32'h0);
        chk("reset:onehot_err", 32'(onehot_err_out), 32'h0);
        rst = 1'b1;
        @(posedge clk); #1;

        // basic forward shift
        mode = 1'b1; shift_en = 1'b1; shift_amt = 1'b0; k1 = 8'd3; rot_freq = '0;
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("basic");
        chk("basic:lit", 32'(dout), 32'h44);

        // idle cycle holds outputs
        set_char(1'b0, 1'b0, 1'b0, 32'h0000_00ff);
        step("hold");
        chk("hold:lit", 32'(dout), 32'h44);

        // wrap and decrypt
        k1 = 8'd1;
        set_char(1'b1, 1'b0, 1'b1, oh(25));
        step("wrap_z");
        chk("wrap_z:lit", 32'(dout), 32'h61);
        shift_amt = 1'b1;
        set_char(1'b1, 1'b0, 1'b1, oh(0));
        step("dec_a");
        chk("dec_a:lit", 32'(dout), 32'h7a);
        shift_amt = 1'b0; k1 = 8'd255;
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("k255");
        chk("k255:lit", 32'(dout), 32'h56);
        k1 = 8'd26;
        set_char(1'b1, 1'b1, 1'b1, oh(7));
        step("k26_both");
        chk("k26_both:lit", 32'(dout), 32'h48);

        // key rotation
        k1 = 8'd1; k2 = 8'd2; k3 = 8'd3; rot_freq = 3'd2;
        clear_counters();
        for (int i = 0; i < 7; i++) begin
            set_char(1'b1, 1'b1, 1'b0, oh(0));
            step("rot");
            chk("rot:lit_dout", 32'(dout), 32'(exp_rot_ch[i]));
            chk("rot:lit_ks", 32'(key_sel_out), 32'(exp_rot_ks[i]));
        end

        // non-alpha interleave
        clear_counters();
        for (int i = 0; i < 5; i++) begin
            if (i % 2 == 1) set_char(1'b1, 1'b0, 1'b0, 32'h20);
            else            set_char(1'b1, 1'b1, 1'b0, oh(0));
            step("mix");
            chk("mix:lit", 32'(dout), 32'(exp_mix[i]));
        end

        // one-hot error leaves the counter alone
        clear_counters();
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("err_pre");
        set_char(1'b1, 1'b1, 1'b0, 32'h3);
        step("err");
        chk("err:lit_dout", 32'(dout), 32'h03);
        chk("err:lit_flag", 32'(onehot_err_out), 32'h1);
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("err_post1");
        chk("err_post1:lit", 32'(dout), 32'h42);
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("err_post2");
        chk("err_post2:lit", 32'(dout), 32'h43);
        chk("err_post2:lit_flag", 32'(onehot_err_out), 32'h0);

        // bypass clears counters
        mode = 1'b0;
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("bypass");
        chk("bypass:lit", 32'(dout), 32'h01);
        mode = 1'b1;
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("after_bypass");
        chk("after_bypass:lit", 32'(dout), 32'h42);
        chk("after_bypass:lit_ks", 32'(key_sel_out), 32'h0);

        // rot_freq shrinks mid-group
        rot_freq = 3'd4;
        clear_counters();
        for (int i = 0; i < 3; i++) begin
            set_char(1'b1, 1'b1, 1'b0, oh(0));
            step("shrink_pre");
        end
        rot_freq = 3'd2;
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("shrink_wrap");
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("shrink_next");
        chk("shrink_next:lit", 32'(key_sel_out), 32'h1);

        // asynchronous reset between edges
        k1 = 8'd3;
        set_char(1'b1, 1'b1, 1'b0, oh(2));
        step("pre_rst");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst:dout", 32'(dout), 32'h0);
        chk("async_rst:en_out", 32'(en_out), 32'h0);
        chk("async_rst:key_sel_out", 32'(key_sel_out), 32'h0);
        chk("async_rst:onehot_err", 32'(onehot_err_out), 32'h0);
        #2 rst = 1'b1;
        set_char(1'b1, 1'b1, 1'b0, oh(0));
        step("post_rst");
        chk("post_rst:lit", 32'(dout), 32'h44);

        // random traffic
        for (int n = 0; n < 400; n++) begin
            k1 = 8'($urandom_range(0, 255));
            k2 = 8'($urandom_range(0, 255));
            k3 = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 19) == 0) rot_freq = RW'($urandom_range(0, 7));
            mode      = ($urandom_range(0, 9) != 0);
            shift_en  = ($urandom_range(0, 6) != 0);
            shift_amt = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 4) != 0);
            kind = $urandom_range(0, 7);
            if (kind <= 5) begin
                a = $urandom_range(0, 2);
                up = (a != 1); lo = (a != 0);
                data = oh($urandom_range(0, NL - 1));
            end else if (kind == 6) begin
                up = 1'b0; lo = 1'b0;
                data = 32'($urandom_range(0, 255));
            end else begin
                up = 1'($urandom_range(0, 1)); lo = ~up;
                a = $urandom_range(0, NL - 1);
                b = (a + $urandom_range(1, NL - 1)) % NL;
                data = ($urandom_range(0, 3) == 0) ? 32'h0 : (oh(a) | oh(b));
            end
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
